// File: rtl/datapath_sequencer.sv
// datapath_sequencer: three-cycle IDLE/EXEC/WB sequencer that drives register-bank and ALU selects.
// All outputs are registered; selects appear in EXEC and the write strobe and done appear in WB.
module datapath_sequencer #(
    parameter int RETIRE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic                acc_sel,
    output logic [2:0]          source_sel,
    output logic [3:0]          destination_sel,
    output logic [1:0]          alu_b_sel,
    output logic [1:0]          bank_out_sel,
    output logic [2:0]          operation_select,
    output logic [7:0]          bank_data_in,
    output logic                out_valid,
    output logic                done,
    output logic                illegal_op,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired
);
    typedef enum logic [1:0] {IDLE, EXEC, WB, HALT} state_t;
    typedef struct packed {
        logic       acc;
        logic [2:0] src;
        logic [1:0] alu_b;
        logic [1:0] bank_out;
        logic [2:0] op;
        logic [7:0] data;
    } sel_t;
    state_t     state, state_n;
    sel_t       sel, sel_n, dec;
    logic [3:0] op, op_q, dest_wb, dest_n;
    logic [1:0] rd_q;
    logic       ready_n, done_n, out_valid_n, illegal_n, halted_n;
    assign op = instr[15:12];
    always_comb begin
        dec.acc      = (op == 4'h1 || op == 4'h2) && instr[11:10] == 2'd0;
        dec.src      = op == 4'h1 ? 3'b100 : op == 4'h2 ? {1'b0, instr[9:8]} : 3'b000;
        dec.alu_b    = op[3] ? instr[9:8] : 2'd0;
        dec.bank_out = op == 4'h3 ? instr[9:8] : 2'd0;
        dec.op       = op[3] ? op[2:0] : 3'd0;
        dec.data     = op == 4'h1 ? instr[7:0] : 8'd0;
    end
    // ALU results always land in ACC; LDI/MOV write the register named by rd
    assign dest_wb = op_q[3] ? 4'b0001 : (op_q == 4'h1 || op_q == 4'h2) ? 4'b0001 << rd_q : 4'b0000;
    always_comb begin
        state_n     = state;
        sel_n       = '0;
        dest_n      = 4'b0000;
        ready_n     = 1'b0;
        done_n      = 1'b0;
        out_valid_n = 1'b0;
        illegal_n   = 1'b0;
        halted_n    = 1'b0;
        case (state)
            IDLE: begin
                ready_n = !instr_valid;
                if (instr_valid) begin
                    state_n = EXEC;
                    sel_n   = dec;
                end
            end
            EXEC: begin
                state_n     = WB;
                sel_n       = sel;
                dest_n      = dest_wb;
                done_n      = 1'b1;
                out_valid_n = op_q == 4'h3;
                illegal_n   = op_q inside {4'h5, 4'h6, 4'h7};
            end
            WB: begin
                state_n  = op_q == 4'h4 ? HALT : IDLE;
                ready_n  = op_q != 4'h4;
                halted_n = op_q == 4'h4;
            end
            default: halted_n = 1'b1;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            sel             <= '0;
            op_q            <= '0;
            rd_q            <= '0;
            destination_sel <= '0;
            instr_ready     <= 1'b1;
            done            <= 1'b0;
            out_valid       <= 1'b0;
            illegal_op      <= 1'b0;
            halted          <= 1'b0;
            retired         <= '0;
        end else begin
            state           <= state_n;
            sel             <= sel_n;
            destination_sel <= dest_n;
            instr_ready     <= ready_n;
            done            <= done_n;
            out_valid       <= out_valid_n;
            illegal_op      <= illegal_n;
            halted          <= halted_n;
            if (state == IDLE && instr_valid) begin
                op_q <= instr[15:12];
                rd_q <= instr[11:10];
            end
            if (state == EXEC) retired <= retired + RETIRE_W'(1);
        end
    end
    assign acc_sel          = sel.acc;
    assign source_sel       = sel.src;
    assign alu_b_sel        = sel.alu_b;
    assign bank_out_sel     = sel.bank_out;
    assign operation_select = sel.op;
    assign bank_data_in     = sel.data;
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: vector table, random instructions against an opcode-level model,
// and hand-written sequences for back-to-back issue, reset mid-instruction, wrap and halt.
module tb_datapath_sequencer;
    localparam int W = 8;
    logic         clk, reset, instr_valid, instr_ready, acc_sel, out_valid, done, illegal_op, halted;
    logic [15:0]  instr;
    logic [2:0]   source_sel, operation_select;
    logic [3:0]   destination_sel;
    logic [1:0]   alu_b_sel, bank_out_sel;
    logic [7:0]   bank_data_in;
    logic [W-1:0] retired;

    typedef struct packed {
        logic       acc;
        logic [2:0] src;
        logic [1:0] alu_b;
        logic [1:0] bank_out;
        logic [2:0] opsel;
        logic [7:0] data;
        logic [3:0] dest;
        logic       outv;
        logic       ill;
    } exp_t;
    typedef struct {
        logic [15:0] ins;
        exp_t        e;
    } vec_t;

    int vectors = 0, miscompares = 0, rcount = 0;
    vec_t tbl[10];

    datapath_sequencer #(.RETIRE_W(W)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .acc_sel(acc_sel), .source_sel(source_sel),
        .destination_sel(destination_sel), .alu_b_sel(alu_b_sel), .bank_out_sel(bank_out_sel),
        .operation_select(operation_select), .bank_data_in(bank_data_in), .out_valid(out_valid),
        .done(done), .illegal_op(illegal_op), .halted(halted), .retired(retired)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic exp_t obs();
        return {acc_sel, source_sel, alu_b_sel, bank_out_sel, operation_select, bank_data_in,
                destination_sel, out_valid, illegal_op};
    endfunction

    function automatic exp_t mk(input logic acc, input logic [2:0] src, input logic [1:0] ab,
                                input logic [1:0] bo, input logic [2:0] op, input logic [7:0] d,
                                input logic [3:0] dest, input logic ov, input logic il);
        return {acc, src, ab, bo, op, d, dest, ov, il};
    endfunction

    // Opcode-level reference: what each instruction class should do in its WB cycle
    function automatic exp_t model(input logic [15:0] i);
        exp_t e = '0;
        int opc = int'(i[15:12]);
        int rd = int'(i[11:10]);
        int rs = int'(i[9:8]);
        if (opc >= 8) begin
            e.opsel = 3'(opc - 8);
            e.alu_b = 2'(rs);
            e.dest  = 4'd1;
        end else if (opc == 1 || opc == 2) begin
            e.src  = opc == 1 ? 3'd4 : 3'(rs);
            e.data = opc == 1 ? i[7:0] : 8'd0;
            e.dest = 4'(1 << rd);
            e.acc  = rd == 0;
        end else if (opc == 3) begin
            e.bank_out = 2'(rs);
            e.outv     = 1'b1;
        end else if (opc >= 5) begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic do_reset();
        reset = 1; instr_valid = 0; #1;
        chk("reset", {obs(), done, instr_ready, halted, retired}, {25'b0, 1'b0, 1'b1, 1'b0, 8'd0});
        @(posedge clk); #1 reset = 0; rcount = 0;
    endtask

    // Issue one instruction from IDLE and check EXEC, WB and the cycle after
    task automatic run(input logic [15:0] i, input exp_t e);
        exp_t ex = e;
        ex.dest = 0; ex.outv = 0; ex.ill = 0;
        instr = i; instr_valid = 1;
        @(posedge clk); #1 instr_valid = 0; instr = 16'($urandom);
        chk("exec", {obs(), done, instr_ready}, {ex, 1'b0, 1'b0});
        @(posedge clk); #1;
        rcount = (rcount + 1) % (1 << W);
        chk("wb", {obs(), done, instr_ready}, {e, 1'b1, 1'b0});
        chk("retired", retired, rcount);
        @(posedge clk); #1;
        if (i[15:12] == 4'h4) chk("halt", {obs(), done, instr_ready, halted}, {25'b0, 1'b0, 1'b0, 1'b1});
        else chk("idle", {obs(), done, instr_ready, halted}, {25'b0, 1'b0, 1'b1, 1'b0});
    endtask

    initial begin
        logic [15:0] r;
        instr = 0; instr_valid = 0; reset = 1;
        tbl[0] = '{16'h1455, mk(0, 3'b100, 0, 0, 0, 8'h55, 4'b0010, 0, 0)};
        tbl[1] = '{16'h10AA, mk(1, 3'b100, 0, 0, 0, 8'hAA, 4'b0001, 0, 0)};
        tbl[2] = '{16'h8100, mk(0, 3'b000, 2'b01, 0, 3'b000, 0, 4'b0001, 0, 0)};
        tbl[3] = '{16'h2A00, mk(0, 3'b010, 0, 0, 0, 0, 4'b0100, 0, 0)};
        tbl[4] = '{16'h2300, mk(1, 3'b011, 0, 0, 0, 0, 4'b0001, 0, 0)};
        tbl[5] = '{16'h3200, mk(0, 0, 0, 2'b10, 0, 0, 4'b0000, 1, 0)};
        tbl[6] = '{16'h0FFF, mk(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0)};
        tbl[7] = '{16'h5ABC, mk(0, 0, 0, 0, 0, 0, 4'b0000, 0, 1)};
        tbl[8] = '{16'hFF12, mk(0, 0, 2'b11, 0, 3'b111, 0, 4'b0001, 0, 0)};
        tbl[9] = '{16'h1C00, mk(0, 3'b100, 0, 0, 0, 8'h00, 4'b1000, 0, 0)};
        do_reset();
        for (int k = 0; k < 10; k++) run(tbl[k].ins, tbl[k].e);
        for (int k = 0; k < 40; k++) begin
            r = 16'($urandom);
            if (r[15:12] == 4'h4) r[15:12] = 4'h0;
            run(r, model(r));
        end
        // Back-to-back issue with instr_valid held high
        do_reset();
        instr = 16'h1400; instr_valid = 1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            chk("b2b_ready", instr_ready, c % 3 == 2);
            chk("b2b_done", done, c % 3 == 1);
            if (c % 3 == 0) chk("b2b_data", bank_data_in, 8'(c / 3));
            if (c % 3 == 2) instr = 16'h1400 | 16'(c / 3 + 1);
        end
        instr_valid = 0;
        chk("b2b_retired", retired, 8'd4);
        // Reset mid-EXEC of LDI rd=2
        instr = 16'h1833; instr_valid = 1;
        @(posedge clk); #1 instr_valid = 0;
        chk("rst_pre_exec", bank_data_in, 8'h33);
        reset = 1; #1;
        chk("rst_async", {obs(), done, instr_ready, halted, retired}, {25'b0, 1'b0, 1'b1, 1'b0, 8'd0});
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("rst_no_done", {done, destination_sel}, 5'd0);
        end
        reset = 0; rcount = 0;
        run(16'h1455, model(16'h1455));
        // Retired counter wrap
        do_reset();
        for (int k = 0; k < (1 << W) + 1; k++) run(16'h0000, '0);
        chk("wrap", retired, 8'd1);
        // Illegal opcode, HALT, then ignored instructions
        do_reset();
        run(16'h6000, model(16'h6000));
        run(16'h4000, model(16'h4000));
        instr = 16'h1455; instr_valid = 1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("halted", {instr_ready, halted, done, destination_sel, retired}, {1'b0, 1'b1, 1'b0, 4'd0, 8'd2});
        end
        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 Parameter: RETIRE_W, default 8, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 instr  input  16  instruction word: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
REQ-005 instr_valid  input  1  instr is valid this cycle.
REQ-006 instr_ready  output  1  sequencer can accept an instruction.
REQ-007 acc_sel  output  1  accumulator input: 1 = bank source, 0 = alu_out.
REQ-008 source_sel  output  3  bank write source: 3'b0rr = register rr, 3'b100 = bank_data_in.
REQ-009 destination_sel  output  4  one-hot write strobe: bit0 ACC, bit1 R1, bit2 R2, bit3 R3; 4'b0000 = no write.
REQ-010 alu_b_sel  output  2  register driven onto ALU B operand.
REQ-011 bank_out_sel  output  2  register driven onto bank_data_out.
REQ-012 operation_select  output  3  ALU operation code.
REQ-013 bank_data_in  output  8  immediate data to the register bank.
REQ-014 out_valid  output  1  bank_data_out is valid for an OUT instruction this cycle.
REQ-015 done  output  1  one-cycle pulse at completion of each instruction.
REQ-016 illegal_op  output  1  one-cycle pulse, coincident with done, for an unassigned opcode.
REQ-017 halted  output  1  high after a HALT instruction until reset.
REQ-018 retired  output  RETIRE_W  count of completed instructions.

Function
REQ-019 States: IDLE, EXEC, WB, HALT; every output is registered (Moore).
REQ-020 IDLE: instr_ready=1; an instruction is accepted on a rising edge where instr_valid=1; the edge latches instr and moves the FSM to EXEC.
REQ-021 EXEC and WB: instr_ready=0; instr_valid is ignored.
REQ-022 EXEC always proceeds to WB after exactly one cycle.
REQ-023 WB asserts done; asserts the write strobe or out_valid for the decoded opcode; then returns to IDLE, or to HALT for HALT.
REQ-024 Timing: accept at edge k; EXEC is cycle k+1; WB is cycle k+2; instr_ready is high again in cycle k+3. Throughput is one instruction per 3 cycles.
REQ-025 Select fields (acc_sel, source_sel, alu_b_sel, bank_out_sel, operation_select, bank_data_in) take their decoded values in EXEC and hold them unchanged through WB.
REQ-026 destination_sel is non-zero only in WB.
REQ-027 In IDLE and HALT, all select fields are zero and destination_sel=4'b0000.
REQ-028 Decode:
- 0000 NOP: no write.
- 0001 LDI: source_sel=100, bank_data_in=imm, destination_sel=onehot(rd), acc_sel=(rd==0).
- 0010 MOV: source_sel={0,rs}, destination_sel=onehot(rd), acc_sel=(rd==0).
- 0011 OUT: bank_out_sel=rs, out_valid=1 in WB, no write.
- 0100 HALT: no write.
- 1ooo ALU: operation_select=ooo, alu_b_sel=rs, acc_sel=0, destination_sel=0001 (result to ACC; rd ignored).
- 0101 to 0111: treated as NOP, with illegal_op=1 in WB.
REQ-029 MOV with rd==rs still performs the write.
REQ-030 retired increments by 1 in every WB cycle, including NOP, illegal, and HALT; it wraps from all-ones to zero.
REQ-031 HALT state: halted=1, instr_ready=0; the FSM leaves HALT only on reset.

Reset
REQ-032 Asserting reset immediately, with no clock edge needed, forces state=IDLE, all outputs to zero except instr_ready=1, and retired=0, including mid-EXEC or mid-WB.
REQ-033 An instruction interrupted by reset is discarded: no destination_sel strobe and no done pulse.
REQ-034 After reset deasserts, the first instruction can be accepted on the first rising edge with instr_valid=1.

Verification
REQ-035 LDI rd=1, imm=0x55 -> EXEC: source_sel=100, bank_data_in=0x55, destination_sel=0000; WB: destination_sel=0010, done=1; retired 0->1.
REQ-036 LDI rd=0, imm=0xAA; then ALU 1000, rs=1 -> second WB: acc_sel=0, alu_b_sel=01, operation_select=000, destination_sel=0001; with the real bank and ALU, ACC equals alu_out(0xAA, 0x55).
REQ-037 instr_valid held high with back-to-back instructions -> accepts spaced exactly 3 cycles apart; instr_ready=0 in EXEC and WB; no instruction lost or duplicated.
REQ-038 Opcode 0110, then HALT, then valid instructions -> illegal_op pulse with no write; halted=1; instr_ready stays 0; retired=2 until reset.
REQ-039 Reset asserted mid-EXEC of LDI rd=2 -> destination_sel=0000 immediately; no done; R2 unchanged; retired=0.
REQ-040 2^RETIRE_W + 1 NOPs -> retired wraps to 1.
